axi4_ax_buffer: RTL
===================

# axi4_ax_buffer

Parametrised AXI4 address-channel buffer for either the AR or the AW channel. Sits between an upstream master port and the RAB translation/slave side. Provides a configurable-depth FIFO with fill-level reporting. Adds an outstanding-transaction limiter that withholds issue once MAX_OUTSTANDING bursts are in flight without completion.

## Interface
- AXI_ADDR_WIDTH, 32, address width
- AXI_ID_WIDTH, 4, ID width
- AXI_USER_WIDTH, 4, user width
- DEPTH, 4, FIFO entries; power of two, ≥2
- ALMOST_FULL_THRESH, DEPTH-1, fill level at and above which almost_full asserts; 1..DEPTH
- MAX_OUTSTANDING, 8, in-flight limit; 0 = unlimited
- axi4_aclk  in  1  clock; all logic on rising edge
- axi4_arst  in  1  reset; synchronous, active-high
- s_axi4_axid / axaddr / axlen / axsize / axburst / axlock / axprot / axcache / axuser  in  ID/ADDR/8/3/2/1/3/4/USER  upstream request fields
- s_axi4_axvalid  in  1;  s_axi4_axready  out  1
- m_axi4_ax* (same nine fields)  out  same widths  downstream request fields
- m_axi4_axvalid  out  1;  m_axi4_axready  in  1
- txn_done  in  1  one-cycle pulse per completed burst (RLAST or B handshake)
- fill_level  out  $clog2(DEPTH+1)  FIFO occupancy
- almost_full  out  1  fill_level ≥ ALMOST_FULL_THRESH
- outstanding_cnt  out  $clog2(MAX_OUTSTANDING+1) (min 1)  issued, not yet completed bursts

## Operation
- Push on s_axi4_axvalid & s_axi4_axready. Pop on m_axi4_axvalid & m_axi4_axready. Both may occur in one cycle; fill_level is then unchanged.
- s_axi4_axready = (fill_level < DEPTH) & !axi4_arst. Depends on registered state only; no combinational path from m_axi4_axready.
- limit_ok = (MAX_OUTSTANDING == 0) | (outstanding_cnt < MAX_OUTSTANDING).
- m_axi4_axvalid = !empty & limit_ok. m_axi4_ax* is the head entry, bit-exact, in order.
- Once m_axi4_axvalid rises it stays high until the handshake. outstanding_cnt rises only on this block's own handshake, so limit_ok cannot fall while valid is pending.
- Outstanding counter:
  - +1 on pop; −1 on txn_done; pop and txn_done together leave it unchanged.
  - txn_done at 0 is ignored (stays 0); sim-only assertion fires.
  - Never exceeds MAX_OUTSTANDING.
- When MAX_OUTSTANDING == 0, outstanding_cnt is held at 0 and txn_done is ignored.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (axi4_arst high at edge), holding while asserted:
  - fill_level = 0, outstanding_cnt = 0, pointers = 0, storage = 0
  - m_axi4_axvalid = 0, m_axi4_ax* = 0, almost_full = 0, s_axi4_axready = 0
- Reset mid-operation discards all buffered entries and the outstanding count. The first request is accepted on the first cycle after deassertion.
- Registered mode latency: accepted at edge N, m_axi4_axvalid high from cycle N+1.
- Full throughput: 1 transfer/cycle when downstream is always ready and the limit is not reached.
- Full: push refused even if a pop occurs that cycle. ready returns the cycle after the pop.
- fill_level, almost_full and outstanding_cnt are registered and reflect the state after the last edge.

## Configuration
- AXI4_AX_BUFFER_FALL_THROUGH_EN defined:
  - When the FIFO is empty and limit_ok, s_axi4_axvalid and s_axi4_ax* pass combinationally to m_axi4_ax*.
  - A same-cycle downstream handshake bypasses storage (0-cycle latency, no fill_level change).
  - If not taken, the request is written normally.
  - s_axi4_axready is unchanged (state-only).
- Undefined: strictly registered; 1-cycle minimum latency.

## Structure
- Package axi4_buffer_pkg holds:
  - field width constants AXI_LEN_W=8, AXI_SIZE_W=3, AXI_BURST_W=2, AXI_CACHE_W=4, AXI_PROT_W=3
  - payload bit offsets
  - pack/unpack functions parameterised by ID/USER/ADDR widths through function arguments widths sized to the max, truncated at use
- One sub-module, axi4_ax_fifo: generic DATA_WIDTH × DEPTH storage, read/write pointers, occupancy counter, full/empty.
- Top level holds packing, the outstanding limiter, fall-through muxing and the txn_done assertion.

## Test plan
- Reset then 4 back-to-back requests (addr 0x1000, 0x2000, 0x3000, 0x4000; DEPTH=4; m ready low) → ready drops after 4th, fill_level=4, almost_full=1; release ready → same order out, one per cycle.
- Streaming with m ready always high, 100 random requests → bit-exact, in order; ready never low; registered latency exactly 1 cycle.
- MAX_OUTSTANDING=2, no txn_done → exactly 2 issued, valid low with fill_level≥1; single txn_done pulse → third issued next cycle.
- Pop and txn_done same cycle at outstanding_cnt=1 → stays 1. txn_done at 0 → stays 0, assertion reported.
- Reset asserted with 3 entries buffered and outstanding_cnt=2 → next cycle all outputs 0; after deassertion a new request 0xABC0 is the first issued.
- FALL_THROUGH_EN, empty FIFO, m ready high, request 0x5000 → m valid and addr 0x5000 in same cycle, fill_level stays 0.

Source files
------------

// File: rtl/axi4_buffer_pkg.sv
// axi4_buffer_pkg: AXI4 address-channel field widths, payload layout and pack/unpack helpers
package axi4_buffer_pkg;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_CACHE_W = 4;
    localparam int AXI_PROT_W  = 3;
    localparam int AXI_MAX_ID_W   = 32;
    localparam int AXI_MAX_ADDR_W = 64;
    localparam int AXI_MAX_USER_W = 32;
    localparam int OFF_PROT  = 0;
    localparam int OFF_CACHE = OFF_PROT + AXI_PROT_W;
    localparam int OFF_LOCK  = OFF_CACHE + AXI_CACHE_W;
    localparam int OFF_BURST = OFF_LOCK + 1;
    localparam int OFF_SIZE  = OFF_BURST + AXI_BURST_W;
    localparam int OFF_LEN   = OFF_SIZE + AXI_SIZE_W;
    localparam int OFF_ADDR  = OFF_LEN + AXI_LEN_W;
    localparam int PAY_MAX_W = OFF_ADDR + AXI_MAX_ADDR_W + AXI_MAX_USER_W + AXI_MAX_ID_W;

    typedef struct packed {
        logic [AXI_MAX_ID_W-1:0]   id;
        logic [AXI_MAX_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]      len;
        logic [AXI_SIZE_W-1:0]     size;
        logic [AXI_BURST_W-1:0]    burst;
        logic                      lock;
        logic [AXI_PROT_W-1:0]     prot;
        logic [AXI_CACHE_W-1:0]    cache;
        logic [AXI_MAX_USER_W-1:0] user;
    } ax_req_t;

    function automatic int payload_w(input int id_w, input int addr_w, input int user_w);
        return OFF_ADDR + addr_w + user_w + id_w;
    endfunction

    function automatic logic [63:0] width_mask(input int w);
        return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    endfunction

    // Variable-width fields sit above the fixed ones: addr, then user, then id.
    function automatic logic [PAY_MAX_W-1:0] ax_pack(input ax_req_t r, input int addr_w, input int user_w);
        logic [PAY_MAX_W-1:0] p;
        p = PAY_MAX_W'({r.len, r.size, r.burst, r.lock, r.cache, r.prot});
        p = p | (PAY_MAX_W'(r.addr) << OFF_ADDR);
        p = p | (PAY_MAX_W'(r.user) << (OFF_ADDR + addr_w));
        p = p | (PAY_MAX_W'(r.id) << (OFF_ADDR + addr_w + user_w));
        return p;
    endfunction

    function automatic ax_req_t ax_unpack(input logic [PAY_MAX_W-1:0] p, input int id_w, input int addr_w, input int user_w);
        ax_req_t r;
        r.prot  = p[OFF_PROT +: AXI_PROT_W];
        r.cache = p[OFF_CACHE +: AXI_CACHE_W];
        r.lock  = p[OFF_LOCK];
        r.burst = p[OFF_BURST +: AXI_BURST_W];
        r.size  = p[OFF_SIZE +: AXI_SIZE_W];
        r.len   = p[OFF_LEN +: AXI_LEN_W];
        r.addr  = AXI_MAX_ADDR_W'(p >> OFF_ADDR) & AXI_MAX_ADDR_W'(width_mask(addr_w));
        r.user  = AXI_MAX_USER_W'(p >> (OFF_ADDR + addr_w)) & AXI_MAX_USER_W'(width_mask(user_w));
        r.id    = AXI_MAX_ID_W'(p >> (OFF_ADDR + addr_w + user_w)) & AXI_MAX_ID_W'(width_mask(id_w));
        return r;
    endfunction
endpackage

// File: rtl/axi4_ax_fifo.sv
// axi4_ax_fifo: generic DATA_WIDTH x DEPTH FIFO with occupancy count; head entry always visible on dout
module axi4_ax_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = count == CNT_W'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/axi4_ax_buffer.sv
// axi4_ax_buffer: AXI4 AR/AW request buffer with outstanding-burst limiter.
// Define AXI4_AX_BUFFER_FALL_THROUGH_EN to let requests bypass an empty FIFO.
module axi4_ax_buffer
    import axi4_buffer_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH = 4,
    parameter int AXI_USER_WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int ALMOST_FULL_THRESH = DEPTH - 1,
    parameter int MAX_OUTSTANDING = 8,
    localparam int FILL_W = $clog2(DEPTH + 1),
    localparam int OUT_W = (MAX_OUTSTANDING == 0) ? 1 : $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                      axi4_aclk,
    input  logic                      axi4_arst,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi4_axid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi4_axaddr,
    input  logic [AXI_LEN_W-1:0]      s_axi4_axlen,
    input  logic [AXI_SIZE_W-1:0]     s_axi4_axsize,
    input  logic [AXI_BURST_W-1:0]    s_axi4_axburst,
    input  logic                      s_axi4_axlock,
    input  logic [AXI_PROT_W-1:0]     s_axi4_axprot,
    input  logic [AXI_CACHE_W-1:0]    s_axi4_axcache,
    input  logic [AXI_USER_WIDTH-1:0] s_axi4_axuser,
    input  logic                      s_axi4_axvalid,
    output logic                      s_axi4_axready,
    output logic [AXI_ID_WIDTH-1:0]   m_axi4_axid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi4_axaddr,
    output logic [AXI_LEN_W-1:0]      m_axi4_axlen,
    output logic [AXI_SIZE_W-1:0]     m_axi4_axsize,
    output logic [AXI_BURST_W-1:0]    m_axi4_axburst,
    output logic                      m_axi4_axlock,
    output logic [AXI_PROT_W-1:0]     m_axi4_axprot,
    output logic [AXI_CACHE_W-1:0]    m_axi4_axcache,
    output logic [AXI_USER_WIDTH-1:0] m_axi4_axuser,
    output logic                      m_axi4_axvalid,
    input  logic                      m_axi4_axready,
    input  logic                      txn_done,
    output logic [FILL_W-1:0]         fill_level,
    output logic                      almost_full,
    output logic [OUT_W-1:0]          outstanding_cnt
);
    localparam int PW = payload_w(AXI_ID_WIDTH, AXI_ADDR_WIDTH, AXI_USER_WIDTH);

    ax_req_t s_req, m_req;
    logic [PAY_MAX_W-1:0] s_pay_full;
    logic [PW-1:0] s_pay, head_pay, m_pay;
    logic push, pop, issue, full, empty, limit_ok;

    always_comb begin
        s_req = '0;
        s_req.id    = AXI_MAX_ID_W'(s_axi4_axid);
        s_req.addr  = AXI_MAX_ADDR_W'(s_axi4_axaddr);
        s_req.len   = s_axi4_axlen;
        s_req.size  = s_axi4_axsize;
        s_req.burst = s_axi4_axburst;
        s_req.lock  = s_axi4_axlock;
        s_req.prot  = s_axi4_axprot;
        s_req.cache = s_axi4_axcache;
        s_req.user  = AXI_MAX_USER_W'(s_axi4_axuser);
    end

    assign s_pay_full = ax_pack(s_req, AXI_ADDR_WIDTH, AXI_USER_WIDTH);
    assign s_pay = s_pay_full[PW-1:0];
    assign s_axi4_axready = !full && !axi4_arst;
    assign limit_ok = (MAX_OUTSTANDING == 0) || (outstanding_cnt < OUT_W'(MAX_OUTSTANDING));
    assign issue = m_axi4_axvalid && m_axi4_axready;

`ifdef AXI4_AX_BUFFER_FALL_THROUGH_EN
    logic bypass;
    // A request taken downstream in the same cycle never touches storage.
    assign bypass = empty && limit_ok && !axi4_arst;
    assign m_axi4_axvalid = bypass ? s_axi4_axvalid : (!empty && limit_ok);
    assign m_pay = bypass ? s_pay : head_pay;
    assign push = s_axi4_axvalid && s_axi4_axready && !(bypass && m_axi4_axready);
    assign pop = issue && !bypass;
`else
    assign m_axi4_axvalid = !empty && limit_ok;
    assign m_pay = head_pay;
    assign push = s_axi4_axvalid && s_axi4_axready;
    assign pop = issue;
`endif

    axi4_ax_fifo #(.DATA_WIDTH(PW), .DEPTH(DEPTH)) u_fifo (
        .clk  (axi4_aclk),
        .rst  (axi4_arst),
        .push (push),
        .pop  (pop),
        .din  (s_pay),
        .dout (head_pay),
        .count(fill_level),
        .full (full),
        .empty(empty)
    );

    assign almost_full = fill_level >= FILL_W'(ALMOST_FULL_THRESH);
    assign m_req = ax_unpack(PAY_MAX_W'(m_pay), AXI_ID_WIDTH, AXI_ADDR_WIDTH, AXI_USER_WIDTH);
    assign m_axi4_axid    = m_req.id[AXI_ID_WIDTH-1:0];
    assign m_axi4_axaddr  = m_req.addr[AXI_ADDR_WIDTH-1:0];
    assign m_axi4_axlen   = m_req.len;
    assign m_axi4_axsize  = m_req.size;
    assign m_axi4_axburst = m_req.burst;
    assign m_axi4_axlock  = m_req.lock;
    assign m_axi4_axprot  = m_req.prot;
    assign m_axi4_axcache = m_req.cache;
    assign m_axi4_axuser  = m_req.user[AXI_USER_WIDTH-1:0];

    // Completions with nothing in flight are dropped so the count cannot underflow.
    always_ff @(posedge axi4_aclk) begin
        if (axi4_arst || MAX_OUTSTANDING == 0) outstanding_cnt <= '0;
        else outstanding_cnt <= outstanding_cnt + OUT_W'(issue) - OUT_W'(txn_done && outstanding_cnt != '0);
    end

    always_ff @(posedge axi4_aclk) begin
        if (!axi4_arst && MAX_OUTSTANDING != 0 && txn_done)
            assert (outstanding_cnt != '0) else $warning("txn_done with no outstanding burst");
    end
endmodule
